// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control path: latches opcode/funct on new_instr and sequences
// IDLE->DECODE->EXEC->MEM->WB. It drives the regfile, memory, ALU and mux controls,
// and reports illegal opcodes, memory timeouts and instructions dropped while busy.
// Ports:
//   clk, rst (async, active high)
//   new_instr, opcode, funct, alu_zero, mem_ready
//   busy, done, reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src,
//   ext_zero, alu_ctrl[3:0], pc_src, illegal, timeout, dropped
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT    = 15,
  parameter bit ENABLE_IMM_OPS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_instr,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       busy,
  output logic       done,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       ext_zero,
  output logic [3:0] alu_ctrl,
  output logic       pc_src,
  output logic       illegal,
  output logic       timeout,
  output logic       dropped
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Abort fires in the MEM cycle whose stall would make the count reach MEM_TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic [7:0] cnt_q, cnt_d;

  logic       r_ok, is_lw, is_sw, is_beq;
  logic       is_addi, is_slti, is_andi, is_ori;
  logic       is_imm, legal;
  logic [3:0] alu_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && new_instr) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  always_comb begin
    r_ok    = (op_q == OP_R) &&
              (fn_q == FN_ADD || fn_q == FN_SUB ||
               fn_q == FN_AND || fn_q == FN_OR  ||
               fn_q == FN_NOR || fn_q == FN_SLT);
    is_lw   = (op_q == OP_LW);
    is_sw   = (op_q == OP_SW);
    is_beq  = (op_q == OP_BEQ);
    is_addi = ENABLE_IMM_OPS && (op_q == OP_ADDI);
    is_slti = ENABLE_IMM_OPS && (op_q == OP_SLTI);
    is_andi = ENABLE_IMM_OPS && (op_q == OP_ANDI);
    is_ori  = ENABLE_IMM_OPS && (op_q == OP_ORI);
    is_imm  = is_addi | is_slti | is_andi | is_ori;
    legal   = r_ok | is_lw | is_sw | is_beq | is_imm;
  end

  always_comb begin
    alu_dec = ALU_ADD;
    unique case (1'b1)
      is_lw, is_sw, is_addi: alu_dec = ALU_ADD;
      is_beq:                alu_dec = ALU_SUB;
      is_slti:               alu_dec = ALU_SLT;
      is_andi:               alu_dec = ALU_AND;
      is_ori:                alu_dec = ALU_OR;
      r_ok: begin
        unique case (fn_q)
          FN_SUB:  alu_dec = ALU_SUB;
          FN_AND:  alu_dec = ALU_AND;
          FN_OR:   alu_dec = ALU_OR;
          FN_NOR:  alu_dec = ALU_NOR;
          FN_SLT:  alu_dec = ALU_SLT;
          default: alu_dec = ALU_ADD;
        endcase
      end
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q == S_MEM)
      cnt_d = mem_ready ? cnt_q : cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    ext_zero   = 1'b0;
    alu_ctrl   = ALU_ADD;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;

    if (state_q != S_IDLE) begin
      busy = 1'b1;
      if (legal) begin
        mem_to_reg = is_lw;
        reg_dst    = r_ok;
        alu_src    = is_lw | is_sw | is_imm;
        ext_zero   = is_andi | is_ori;
        alu_ctrl   = alu_dec;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (new_instr)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_src  = alu_zero;
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        // A late ready in the last allowed cycle still counts as success.
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dropped = busy & new_instr;

endmodule
